ex_mem_stage_buf: RTL
=====================

// Module: ex_mem_stage_buf
// PURPOSE
//  Parametrised EX->MEM pipeline stage register with a valid/ready handshake, synchronous flush
//  and an optional 2-entry skid buffer. It lets a multi-cycle memory stage stall without a
//  combinational ready path back into EX. It carries the WB/M control fields, ALU result,
//  store data, zero flag, PC and destination register.
// PARAMETERS
//  DATA_W  32  width of ALU_result, ALU_src2 and PC
//  REG_W    5  width of the destination-register index
//  WB_W     2  WB control field width: {reg write, mem to reg}
//  M_W      3  M control field width: {branch, mem read, mem write}
//  SKID     1  1 = 2-entry skid buffer with registered in_ready; 0 = single entry, pass-through ready
// PORTS
//  clk             in   1       clock, all state on posedge
//  rst_n           in   1       asynchronous active-low reset
//  flush           in   1       synchronous kill of all held entries
//  in_valid        in   1       EX presents a valid instruction
//  in_ready        out  1       stage can accept this cycle
//  WB_in           in   WB_W    WB control
//  M_in            in   M_W     M control
//  ALU_result_in   in   DATA_W  ALU result / memory address
//  ALU_src2_in     in   DATA_W  store data
//  ALU_zero_in     in   1       ALU zero flag
//  PC_in           in   DATA_W  branch target PC
//  REG_dst_in      in   REG_W   destination register
//  out_valid       out  1       MEM slot holds a valid instruction
//  out_ready       in   1       MEM consumes the head entry this cycle
//  WB_out, M_out, ALU_result_out, ALU_src2_out, ALU_zero_out, PC_out, REG_dst_out
//                  out  (as inputs)  head-entry fields
// BEHAVIOUR
//  - Reset (rst_n=0, async): all entries invalid, all outputs 0, in_ready=1 (SKID=1) after release.
//  - Accept when in_valid & in_ready. Emit when out_valid & out_ready. Latency is 1 cycle:
//    accepted at edge N, visible on outputs after edge N.
//  - Bubble rule: WB_out and M_out are 0 whenever out_valid=0. Data fields are don't-care and
//    hold their last value.
//  - SKID=1: storage is head (H) and skid (S). in_ready = ~S.valid, driven from a register.
//    * H empty: accepted entry -> H.
//    * H full & out_ready: H <= S if S valid, else incoming; a simultaneous accept while S
//      valid -> S.
//    * H full & ~out_ready: accepted entry -> S; in_ready drops next cycle.
//    * Order is strictly FIFO. No entry is lost or duplicated. Throughput is 1 per cycle when
//      out_ready=1.
//  - SKID=0: single entry H. in_ready = ~H.valid | out_ready (combinational). H loads on accept.
//  - flush=1 at edge: H.valid=S.valid=0, control fields cleared. An input presented the same
//    cycle is dropped, even if in_valid & in_ready. flush overrides out_ready. The next cycle
//    shows out_valid=0 and in_ready=1.
//  - Reset mid-operation discards all entries immediately (asynchronous), with no partial
//    transfer.
//  - in_valid must not be retracted while ~in_ready. Payload is held stable by EX (protocol rule,
//    asserted in the bench).
// TESTING
//  1) Reset: rst_n=0 mid-stream -> out_valid=0, WB_out=0, M_out=0, ALU_result_out=0
//     immediately; in_ready=1 after release.
//  2) Streaming, out_ready=1: push ALU_result 0x10,0x20,0x30 on consecutive cycles -> same
//     values out on cycles +1..+3, in_ready stays 1.
//  3) Backpressure (SKID=1): out_ready=0, push A=0x11, B=0x22 -> H=A, S=B, in_ready=0.
//     Then out_ready=1 -> A then B, in_ready=1 one cycle after S drains.
//  4) Flush with simultaneous push: H,S full, flush=1 & in_valid=1 (0x99) -> next cycle
//     out_valid=0, M_out=0, WB_out=0; 0x99 never appears.
//  5) Bubble gating: WB_in=2'b11, M_in=3'b010 accepted and then consumed, no new input ->
//     WB_out=0 and M_out=0 while ALU_result_out holds the old value.
//  6) SKID=0 build: out_ready=0 with H full -> in_ready=0 combinationally; out_ready=1 ->
//     in_ready=1 in the same cycle and the back-to-back push succeeds.

Source files
------------

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline stage register with valid/ready handshake, synchronous flush and
// an optional 2-entry skid buffer that keeps in_ready off the combinational path.
module ex_mem_stage_buf #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   WB_in,
  input  logic [M_W-1:0]    M_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] ALU_src2_in,
  input  logic              ALU_zero_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [REG_W-1:0]  REG_dst_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   WB_out,
  output logic [M_W-1:0]    M_out,
  output logic [DATA_W-1:0] ALU_result_out,
  output logic [DATA_W-1:0] ALU_src2_out,
  output logic              ALU_zero_out,
  output logic [DATA_W-1:0] PC_out,
  output logic [REG_W-1:0]  REG_dst_out
);

  localparam int C_W = WB_W + M_W;
  localparam int P_W = C_W + 3 * DATA_W + 1 + REG_W;

  logic [P_W-1:0]  in_pl, h_pl, s_pl;
  logic            h_valid, s_valid, rdy_q;
  logic            h_valid_d, s_valid_d;
  logic            h_load_in, h_load_s, s_load;
  logic            accept;
  logic [WB_W-1:0] h_wb;
  logic [M_W-1:0]  h_m;

  assign in_pl = {WB_in, M_in, ALU_result_in, ALU_src2_in, ALU_zero_in, PC_in, REG_dst_in};

  // With the skid buffer, ready is a flop so EX never sees MEM's stall combinationally.
  assign in_ready = (SKID != 0) ? rdy_q : (~h_valid | out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    h_valid_d = h_valid;
    s_valid_d = s_valid;
    h_load_in = 1'b0;
    h_load_s  = 1'b0;
    s_load    = 1'b0;
    if (flush) begin
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (SKID != 0) begin
      if (!h_valid) begin
        if (accept) begin
          h_load_in = 1'b1;
          h_valid_d = 1'b1;
        end
      end else if (out_ready) begin
        if (s_valid) begin
          h_load_s  = 1'b1;
          s_load    = accept;
          s_valid_d = accept;
        end else if (accept) begin
          h_load_in = 1'b1;
        end else begin
          h_valid_d = 1'b0;
        end
      end else if (accept) begin
        s_load    = 1'b1;
        s_valid_d = 1'b1;
      end
    end else begin
      s_valid_d = 1'b0;
      if (accept) begin
        h_load_in = 1'b1;
        h_valid_d = 1'b1;
      end else if (out_ready) begin
        h_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
      rdy_q   <= 1'b1;
      h_pl    <= '0;
      s_pl    <= '0;
    end else begin
      h_valid <= h_valid_d;
      s_valid <= s_valid_d;
      rdy_q   <= ~s_valid_d;
      if (h_load_s) begin
        h_pl <= s_pl;
      end else if (h_load_in) begin
        h_pl <= in_pl;
      end
      if (s_load) begin
        s_pl <= in_pl;
      end
      // Flush clears only the control fields; data is don't-care once invalid.
      if (flush) begin
        h_pl[P_W-1 -: C_W] <= '0;
        s_pl[P_W-1 -: C_W] <= '0;
      end
    end
  end

  assign {h_wb, h_m, ALU_result_out, ALU_src2_out, ALU_zero_out, PC_out, REG_dst_out} = h_pl;

  assign out_valid = h_valid;
  assign WB_out    = h_valid ? h_wb : '0;
  assign M_out     = h_valid ? h_m  : '0;

endmodule
